// File: rtl/alu_seq_pipe.sv
// ---------------------------------------------------------------------------
// alu_seq_pipe
//
// Registered signed ALU with a valid/ready handshake, an iterative
// sign-magnitude shift-add multiplier and a persistent accumulator.
// Single-cycle ops complete at the accept edge. MUL and MAC run in a MULT
// state for WIDTH edges before they produce a result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand/op presented this cycle
//   in_ready   block can accept (state is IDLE), combinational
//   ctrl       operation select
//                000 MUL, 001 APPEND, 010 ACC, 011 ADD, 100 MAC, 101 CLR
//   A, B       signed WIDTH-bit operands
//   out_valid  one-cycle pulse when out carries a new result
//   out        signed 2*WIDTH-bit result, held between pulses
//   busy       inverse of in_ready
// ---------------------------------------------------------------------------
module alu_seq_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                ctrl,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    output logic                      out_valid,
    output logic signed [2*WIDTH-1:0] out,
    output logic                      busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_APPEND = 3'b001;
    localparam logic [2:0] OP_ACC    = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_MAC    = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;

    typedef enum logic {
        IDLE,
        MULT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   out_q, out_d;
    logic            outValid_q, outValid_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]  mplier_q, mplier_d;
    logic [RW-1:0]   prod_q, prod_d;
    logic            neg_q, neg_d;
    logic            mac_q, mac_d;

    logic            accept;
    logic [RW-1:0]   sextA, sextB;
    logic [WIDTH:0]  wideA, wideB;
    logic [WIDTH:0]  magA, magB;
    logic [RW-1:0]   partial;
    logic [RW-1:0]   signedProd;
    logic [RW-1:0]   accSum;
    logic [RW-1:0]   macSum;

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = outValid_q;

    assign sextA = {{WIDTH{A[WIDTH-1]}}, A};
    assign sextB = {{WIDTH{B[WIDTH-1]}}, B};

    // Magnitudes carry one extra bit so that the most negative operand
    // still has a representable positive magnitude.
    assign wideA = {A[WIDTH-1], A};
    assign wideB = {B[WIDTH-1], B};
    assign magA  = wideA[WIDTH] ? (~wideA + (WIDTH+1)'(1)) : wideA;
    assign magB  = wideB[WIDTH] ? (~wideB + (WIDTH+1)'(1)) : wideB;

    // One shift-add step; on the final step this is the full magnitude.
    assign partial    = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign signedProd = neg_q ? (~partial + RW'(1)) : partial;

    assign accSum = acc_q + sextA + sextB;
    assign macSum = acc_q + signedProd;

    // Next-state and datapath decisions for the IDLE/MULT controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        outValid_d = 1'b0;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        neg_d      = neg_q;
        mac_d      = mac_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (ctrl)
                        OP_MUL, OP_MAC: begin
                            state_d  = MULT;
                            cnt_d    = '0;
                            mcand_d  = RW'(magA);
                            mplier_d = magB;
                            prod_d   = '0;
                            // A zero operand always yields +0.
                            neg_d    = (A[WIDTH-1] ^ B[WIDTH-1]) &&
                                       (A != '0) && (B != '0);
                            mac_d    = (ctrl == OP_MAC);
                        end
                        OP_APPEND: begin
                            out_d      = {A, B};
                            outValid_d = 1'b1;
                        end
                        OP_ACC: begin
                            acc_d      = accSum;
                            out_d      = accSum;
                            outValid_d = 1'b1;
                        end
                        OP_ADD: begin
                            out_d      = sextA + sextB;
                            outValid_d = 1'b1;
                        end
                        OP_CLR: begin
                            acc_d      = '0;
                            out_d      = '0;
                            outValid_d = 1'b1;
                        end
                        default: begin
                            out_d      = '0;
                            outValid_d = 1'b1;
                        end
                    endcase
                end
            end
            MULT: begin
                cnt_d    = cnt_q + CW'(1);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                prod_d   = partial;
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    outValid_d = 1'b1;
                    if (mac_q) begin
                        acc_d = macSum;
                        out_d = macSum;
                    end else begin
                        out_d = signedProd;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset aborts any in-flight multiply immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            neg_q      <= 1'b0;
            mac_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            neg_q      <= neg_d;
            mac_q      <= mac_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_pipe
//
// Scoreboard bench for alu_seq_pipe (WIDTH = 8). Each accepted op pushes
// its expected result into a queue; a monitor on the falling edge pops
// and compares whenever out_valid is high. Directed vectors carry
// hand-computed results, and a reference model supplies the random stream.
// ---------------------------------------------------------------------------
module tb_alu_seq_pipe;

    localparam int W = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ctrl;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic [2*W-1:0] out;
    logic          busy;

    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] refAcc;
    int             errors;
    int             checks;
    int             pulses;

    alu_seq_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl     (ctrl),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out      (out),
        .busy     (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every result pulse must match the oldest entry.
    always @(negedge clk) begin
        logic [2*W-1:0] exp;
        if (rst && out_valid) begin
            pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPulse: got out=%h, required no pulse", out);
            end else begin
                exp = sb.pop_front();
                if (out !== exp) begin
                    errors++;
                    $display("[TB] FAIL result: got out=%h, required %h", out, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one accepted op, including accumulator update.
    task automatic modelStep(input logic [2:0] c, input logic [W-1:0] a,
                             input logic [W-1:0] b, output logic [2*W-1:0] r);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        sa  = {{W{a[W-1]}}, a};
        sbv = {{W{b[W-1]}}, b};
        case (c)
            3'b000: r = sa * sbv;
            3'b001: r = {a, b};
            3'b010: begin refAcc = refAcc + sa + sbv; r = refAcc; end
            3'b011: r = sa + sbv;
            3'b100: begin refAcc = refAcc + sa * sbv; r = refAcc; end
            3'b101: begin refAcc = '0; r = '0; end
            default: r = '0;
        endcase
    endtask

    // Present an op (called at posedge+1) and hold it until accepted.
    task automatic applyStimulus(input logic [2:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit useHand,
                                 input logic [2*W-1:0] hand, output int waited);
        logic [2*W-1:0] m;
        waited   = 0;
        in_valid = 1'b1;
        ctrl     = c;
        A        = a;
        B        = b;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0, required 1");
            in_valid = 1'b0;
            return;
        end
        modelStep(c, a, b, m);
        sb.push_back(useHand ? hand : m);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    // Directed sequence followed by a random stream.
    initial begin
        int waited;
        int lowCount;
        int pulsesBefore;
        logic [2:0] rc;

        errors   = 0;
        checks   = 0;
        pulses   = 0;
        refAcc   = '0;
        rst      = 1'b0;
        in_valid = 1'b0;
        ctrl     = '0;
        A        = '0;
        B        = '0;

        #12;
        checkOutput("resetOut", out, 0);
        checkOutput("resetValid", out_valid, 0);
        checkOutput("resetReady", in_ready, 1);
        checkOutput("resetBusy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("[TB] single-cycle ops");
        applyStimulus(3'b001, 8'h17, 8'hD3, 1, 16'h17D3, waited);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pulseOneCycle", out_valid, 0);
        tick();
        applyStimulus(3'b011, 8'd127, 8'd127, 1, 16'd254, waited);
        applyStimulus(3'b011, 8'h80, 8'h80, 1, 16'hFF00, waited);

        $display("[TB] multiplies");
        applyStimulus(3'b000, 8'h80, 8'h80, 1, 16'h4000, waited);
        lowCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lowCount++;
        end
        checkOutput("mulBusyCycles", lowCount, 8);
        checkOutput("busyAfterMul", busy, 0);
        tick();
        applyStimulus(3'b000, 8'hFD, 8'd5, 1, 16'hFFF1, waited);
        applyStimulus(3'b000, 8'd0, 8'hF9, 1, 16'h0000, waited);
        drain();

        $display("[TB] held in_valid during multiply");
        pulsesBefore = pulses;
        applyStimulus(3'b000, 8'd3, 8'd4, 1, 16'd12, waited);
        applyStimulus(3'b011, 8'd1, 8'd2, 1, 16'd3, waited);
        checkOutput("heldAcceptDelay", waited, 8);
        repeat (3) tick();
        checkOutput("heldPulseCount", pulses - pulsesBefore, 2);

        $display("[TB] accumulator");
        applyStimulus(3'b101, 8'd9, 8'd9, 1, 16'd0, waited);
        applyStimulus(3'b100, 8'd100, 8'd100, 1, 16'd10000, waited);
        applyStimulus(3'b100, 8'd100, 8'd100, 1, 16'd20000, waited);
        applyStimulus(3'b101, 8'd0, 8'd0, 1, 16'd0, waited);
        applyStimulus(3'b010, 8'd127, 8'd127, 1, 16'd254, waited);
        applyStimulus(3'b010, 8'd127, 8'd127, 1, 16'd508, waited);
        applyStimulus(3'b010, 8'd127, 8'd127, 1, 16'd762, waited);
        for (int i = 0; i < 126; i++)
            applyStimulus(3'b010, 8'd127, 8'd127, 0, 16'd0, waited);
        applyStimulus(3'b010, 8'd1, 8'd0, 1, 16'h7FFF, waited);
        applyStimulus(3'b010, 8'd1, 8'd0, 1, 16'h8000, waited);
        applyStimulus(3'b110, 8'd5, 8'd5, 1, 16'd0, waited);
        applyStimulus(3'b010, 8'd0, 8'd0, 1, 16'h8000, waited);
        applyStimulus(3'b111, 8'h7F, 8'h80, 1, 16'd0, waited);
        applyStimulus(3'b010, 8'd0, 8'd0, 1, 16'h8000, waited);
        drain();

        $display("[TB] reset during multiply");
        applyStimulus(3'b000, 8'd50, 8'd50, 1, 16'd2500, waited);
        repeat (3) tick();
        rst = 1'b0;
        sb.delete();
        refAcc = '0;
        #2;
        checkOutput("midResetOut", out, 0);
        checkOutput("midResetValid", out_valid, 0);
        checkOutput("midResetReady", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("postResetOut", out, 0);
        checkOutput("postResetValid", out_valid, 0);
        applyStimulus(3'b100, 8'd2, 8'd3, 1, 16'd6, waited);
        drain();

        $display("[TB] random stream");
        for (int i = 0; i < 800; i++) begin
            rc = 3'($urandom_range(0, 7));
            applyStimulus(rc, 8'($urandom), 8'($urandom), 0, 16'd0, waited);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_pipe.md
# alu_seq_pipe

Parametrised successor to the course-exam registered ALU. It takes signed WIDTH-bit operands, executes one of six operations, and returns a registered 2·WIDTH-bit result. The block adds a valid/ready handshake, an iterative shift-add multiplier, and a persistent accumulator for running-sum and MAC modes. It sits between the operand-feeding logic and result consumers in the datapath.

## Interface
- WIDTH, 8: operand width in bits; result width is 2·WIDTH; legal range ≥ 2.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous active-low reset; 0 resets all state immediately.
- in_valid  in  1  operand/op presented this cycle.
- in_ready  out  1  block can accept; equals (state == IDLE), combinational.
- ctrl  in  3  operation select.
- A, B  in  WIDTH  signed operands (two's complement).
- out_valid  out  1  one-cycle pulse when `out` carries a new result.
- out  out  2·WIDTH  signed result; holds its last value between pulses.
- busy  out  1  equals !in_ready.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready; A, B and ctrl are captured at that edge.
- ctrl encoding:
  - 000 MUL: out = A·B, signed and exact.
  - 001 APPEND: out = {A, B} as raw bits.
  - 010 ACC: acc = acc + sext(A) + sext(B); out = new acc.
  - 011 ADD: out = sext(A) + sext(B).
  - 100 MAC: acc = acc + A·B; out = new acc.
  - 101 CLR: acc = 0; out = 0.
  - 110/111: out = 0; acc unchanged.
- The accumulator `acc` is 2·WIDTH bits and wraps modulo 2^(2·WIDTH); there is no saturation. It persists across operations and is cleared only by CLR or reset.
- Multiplier:
  - Sign-magnitude shift-add over WIDTH iterations. Magnitudes are held in WIDTH+1 bits so that −2^(WIDTH−1) is handled.
  - Final sign = sign(A) XOR sign(B). If either operand is 0, the result is +0.
- FSM states:
  - IDLE: accepts input. A single-cycle op (001, 010, 011, 101, 110, 111) stays in IDLE and writes out/out_valid at the accept edge. MUL/MAC moves to MULT with cnt = 0.
  - MULT: cnt increments each edge. On the edge where cnt == WIDTH−1, the product completes; for MAC it is added into acc. out and out_valid are written, and the state returns to IDLE.
- in_valid is ignored (not queued) while in MULT.
- Back-to-back single-cycle ops are accepted every cycle.

## Timing
- Reset values: out = 0, out_valid = 0, acc = 0, state = IDLE, cnt = 0. After release, in_ready = 1 and busy = 0.
- Single-cycle ops: out/out_valid update at the accept edge, so the result is visible one edge after presentation. That is the same latency as the previous ALU.
- MUL/MAC:
  - Accept at edge k; result and out_valid = 1 after edge k+WIDTH.
  - in_ready is low from after edge k until after edge k+WIDTH; the next accept is possible at edge k+WIDTH+1.
- out_valid is high for exactly one cycle per accepted op. It is 0 on any cycle with no completion.
- Reset mid-MULT: the operation is aborted immediately, with no out_valid and acc = 0.
- Simultaneous completion and in_valid: no accept on the completion edge, because in_ready was 0 before it.
- Operand changes after accept have no effect on an in-flight multiply.

## Test plan
- WIDTH=8, reset, then APPEND A=0x17, B=0xD3 -> next cycle out = 0x17D3, out_valid = 1 for one cycle. ADD A=127, B=127 -> out = 254. ADD A=−128, B=−128 -> out = −256 (0xFF00).
- MUL A=−128, B=−128 -> in_ready low for 8 cycles, then out = 16384 (0x4000). MUL A=−3, B=5 -> out = 0xFFF1. MUL A=0, B=−7 -> out = 0.
- Issue MUL, then hold in_valid high with ADD throughout -> the ADD is accepted only at edge k+9, and exactly two out_valid pulses occur.
- CLR, then MAC (100, 100), then MAC (100, 100) -> out = 10000, then 20000. Then ACC A=127, B=127 repeated -> out increments by 254 per op. With acc preset to 0x7FFF via ACC ops, the next ACC 1,0 -> out = 0x8000 (wrap).
- Assert rst = 0 at cycle 4 of a MUL -> out = 0, out_valid = 0, in_ready = 1 after release. A following MAC 2·3 -> out = 6, confirming acc was cleared.
- Randomised 800-op stream with a mixed ctrl set, checked against a reference model -> zero mismatches. ctrl 110/111 -> out = 0 with acc unchanged.
